// File: rtl/pong_pkg.sv
// Shared types and constants for the pong frame renderer: game states,
// screen geometry, colours and small arithmetic helpers.
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_t;

  localparam logic [23:0] COL_BALL  = 24'hFFFFFF;
  localparam logic [23:0] COL_LEFT  = 24'h00FF00;
  localparam logic [23:0] COL_RIGHT = 24'h0000FF;
  localparam logic [23:0] COL_NET   = 24'h808080;
  localparam logic [23:0] COL_BLACK = 24'h000000;

  // Clamp a wide signed position into [0, hi] and narrow it to 12 bits.
  function automatic logic signed [11:0] clamp_pos(input logic signed [13:0] v,
                                                   input logic signed [13:0] hi);
    if (v < 14'sd0) return 12'sd0;
    else if (v > hi) return hi[11:0];
    else return v[11:0];
  endfunction

  function automatic logic signed [13:0] ext14(input logic signed [11:0] v);
    return {{2{v[11]}}, v};
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_frame_renderer_physics.sv
// Game state for pong: serve/play/over FSM, ball motion with wall and paddle
// bounces, hand-driven left paddle, CPU right paddle and scores. Advances on tick.
module pong_physics
  import pong_pkg::*;
#(
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 4,
  parameter int PAD_W        = 10,
  parameter int PAD_H        = 64,
  parameter int PAD_X        = 16,
  parameter int AI_SPEED     = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [11:0]        hand_y_min,
  input  logic [11:0]        hand_y_max,
  input  logic               start,
  output logic signed [11:0] ball_x,
  output logic signed [11:0] ball_y,
  output logic signed [11:0] left_y,
  output logic signed [11:0] right_y,
  output logic [3:0]         score_l,
  output logic [3:0]         score_r,
  output game_state_t        state
);

  localparam logic signed [11:0] SPD    = 12'(BALL_SPEED);
  localparam logic signed [11:0] BSZ    = 12'(BALL_SIZE);
  localparam logic signed [11:0] PW     = 12'(PAD_W);
  localparam logic signed [11:0] PH     = 12'(PAD_H);
  localparam logic signed [11:0] LPX    = 12'(PAD_X);
  localparam logic signed [11:0] RPX    = 12'(SCREEN_W - PAD_X - PAD_W);
  localparam logic signed [11:0] X_LIM  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] Y_LIM  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] BX0    = 12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic signed [11:0] BY0    = 12'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic signed [11:0] PY0    = 12'((SCREEN_H - PAD_H) / 2);
  localparam logic signed [11:0] AI     = 12'(AI_SPEED);
  localparam logic signed [11:0] NAI    = -AI;
  localparam logic signed [11:0] HB     = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] HP     = 12'(PAD_H / 2);
  localparam logic signed [13:0] HP14   = 14'(PAD_H / 2);
  localparam logic signed [13:0] PMAX14 = 14'(SCREEN_H - PAD_H);
  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]         WIN = 4'(WIN_SCORE);

  logic [7:0]         timer, timer_n;
  logic               dx, dy, dx_n, dy_n;
  game_state_t        state_n;
  logic signed [11:0] bx_n, by_n, ly_n, ry_n;
  logic [3:0]         sl_n, sr_n;

  logic signed [11:0] nx, ny_raw, ny;
  logic               y_flip, hit_l, hit_r;
  logic [12:0]        hand_sum, hand_mid;
  logic signed [11:0] left_tgt, right_tgt, err, step, ry_raw;

  // Candidate ball move for this tick, with wall clamp and paddle overlap tests.
  always_comb begin
    nx     = dx ? ball_x + SPD : ball_x - SPD;
    ny_raw = dy ? ball_y + SPD : ball_y - SPD;
    ny     = ny_raw;
    y_flip = 1'b0;
    if (ny_raw <= 12'sd0) begin
      ny     = 12'sd0;
      y_flip = 1'b1;
    end else if (ny_raw >= Y_LIM) begin
      ny     = Y_LIM;
      y_flip = 1'b1;
    end
    hit_l = !dx && (nx < LPX + PW) && (nx + BSZ > LPX) &&
            (ny + BSZ > left_y) && (ny < left_y + PH);
    hit_r = dx && (nx + BSZ > RPX) && (nx < RPX + PW) &&
            (ny + BSZ > right_y) && (ny < right_y + PH);
  end

  // Paddle targets: left centres on the hand box, right chases the ball centre.
  always_comb begin
    hand_sum  = {1'b0, hand_y_min} + {1'b0, hand_y_max};
    hand_mid  = hand_sum >> 1;
    left_tgt  = clamp_pos($signed({1'b0, hand_mid}) - HP14, PMAX14);
    err       = (ball_y + HB) - (right_y + HP);
    if (err > AI)       step = AI;
    else if (err < NAI) step = NAI;
    else                step = err;
    ry_raw    = right_y + step;
    right_tgt = clamp_pos(ext14(ry_raw), PMAX14);
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    bx_n    = ball_x;
    by_n    = ball_y;
    dx_n    = dx;
    dy_n    = dy;
    sl_n    = score_l;
    sr_n    = score_r;
    ly_n    = left_y;
    ry_n    = right_y;
    if (tick) begin
      if (state != ST_OVER) begin
        if (hand_y_min <= hand_y_max) ly_n = left_tgt;
        ry_n = right_tgt;
      end
      case (state)
        ST_SERVE: begin
          bx_n = BX0;
          by_n = BY0;
          if (timer == SERVE_LAST) begin
            state_n = ST_PLAY;
            timer_n = '0;
          end else begin
            timer_n = timer + 8'd1;
          end
        end
        ST_PLAY: begin
          bx_n = nx;
          by_n = ny;
          dy_n = y_flip ? ~dy : dy;
          // A paddle hit is checked before the miss so an edge contact still returns.
          if (hit_l) begin
            bx_n = LPX + PW;
            dx_n = 1'b1;
          end else if (hit_r) begin
            bx_n = RPX - BSZ;
            dx_n = 1'b0;
          end else if (nx <= 12'sd0) begin
            sr_n    = sat_inc(score_r);
            bx_n    = BX0;
            by_n    = BY0;
            dx_n    = 1'b1;
            timer_n = '0;
            state_n = (sat_inc(score_r) >= WIN) ? ST_OVER : ST_SERVE;
          end else if (nx >= X_LIM) begin
            sl_n    = sat_inc(score_l);
            bx_n    = BX0;
            by_n    = BY0;
            dx_n    = 1'b0;
            timer_n = '0;
            state_n = (sat_inc(score_l) >= WIN) ? ST_OVER : ST_SERVE;
          end
        end
        ST_OVER: begin
          if (start) begin
            sl_n    = '0;
            sr_n    = '0;
            timer_n = '0;
            state_n = ST_SERVE;
          end
        end
        default: state_n = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_SERVE;
      timer   <= '0;
      ball_x  <= BX0;
      ball_y  <= BY0;
      dx      <= 1'b1;
      dy      <= 1'b1;
      left_y  <= PY0;
      right_y <= PY0;
      score_l <= '0;
      score_r <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      ball_x  <= bx_n;
      ball_y  <= by_n;
      dx      <= dx_n;
      dy      <= dy_n;
      left_y  <= ly_n;
      right_y <= ry_n;
      score_l <= sl_n;
      score_r <= sr_n;
    end
  end

endmodule

// File: rtl/pong_frame_renderer.sv
// Pong pixel source for the VGA controller: frame tick detection, game physics,
// per-pixel object tests and a registered RGB output.
module pong_frame_renderer
  import pong_pkg::*;
#(
  parameter int X_START      = 144,
  parameter int Y_START      = 34,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 4,
  parameter int PAD_W        = 10,
  parameter int PAD_H        = 64,
  parameter int PAD_X        = 16,
  parameter int AI_SPEED     = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [12:0] iH_Cont,
  input  logic [12:0] iV_Cont,
  input  logic        iRequest,
  input  logic [11:0] iHand_y_min,
  input  logic [11:0] iHand_y_max,
  input  logic        iStart,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic [3:0]  oScore_L,
  output logic [3:0]  oScore_R,
  output logic [1:0]  oState
);

  localparam logic signed [13:0] XS    = 14'(X_START);
  localparam logic signed [13:0] YS    = 14'(Y_START);
  localparam logic signed [13:0] BSZ   = 14'(BALL_SIZE);
  localparam logic signed [13:0] PW    = 14'(PAD_W);
  localparam logic signed [13:0] PH    = 14'(PAD_H);
  localparam logic signed [13:0] LPX   = 14'(PAD_X);
  localparam logic signed [13:0] RPX   = 14'(SCREEN_W - PAD_X - PAD_W);
  localparam logic signed [13:0] NET_L = 14'(SCREEN_W / 2 - 2);
  localparam logic signed [13:0] NET_R = 14'(SCREEN_W / 2 + 1);
  localparam logic signed [13:0] SH    = 14'(SCREEN_H);

  logic               tick;
  logic signed [11:0] ball_x, ball_y, left_y, right_y;
  game_state_t        state;
  logic signed [13:0] px, py, bx, by, ly, ry;
  logic               in_ball, in_left, in_right, in_net;
  logic [23:0]        colour;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) tick <= 1'b0;
    else         tick <= (iH_Cont == 13'd0) && (iV_Cont == 13'd0);
  end

  pong_physics #(
    .BALL_SIZE   (BALL_SIZE),
    .BALL_SPEED  (BALL_SPEED),
    .PAD_W       (PAD_W),
    .PAD_H       (PAD_H),
    .PAD_X       (PAD_X),
    .AI_SPEED    (AI_SPEED),
    .SERVE_FRAMES(SERVE_FRAMES),
    .WIN_SCORE   (WIN_SCORE)
  ) u_physics (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .tick      (tick),
    .hand_y_min(iHand_y_min),
    .hand_y_max(iHand_y_max),
    .start     (iStart),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .left_y    (left_y),
    .right_y   (right_y),
    .score_l   (oScore_L),
    .score_r   (oScore_R),
    .state     (state)
  );

  assign oState = state;

  // Signed pixel coordinates so blanking-area counters never alias onto the screen.
  always_comb begin
    px       = $signed({1'b0, iH_Cont}) - XS;
    py       = $signed({1'b0, iV_Cont}) - YS;
    bx       = ext14(ball_x);
    by       = ext14(ball_y);
    ly       = ext14(left_y);
    ry       = ext14(right_y);
    in_ball  = (state != ST_OVER) && (px >= bx) && (px < bx + BSZ) &&
               (py >= by) && (py < by + BSZ);
    in_left  = (px >= LPX) && (px < LPX + PW) && (py >= ly) && (py < ly + PH);
    in_right = (px >= RPX) && (px < RPX + PW) && (py >= ry) && (py < ry + PH);
    in_net   = (px >= NET_L) && (px <= NET_R) && (py >= 14'sd0) && (py < SH) && !py[4];
    if (in_ball)       colour = COL_BALL;
    else if (in_left)  colour = COL_LEFT;
    else if (in_right) colour = COL_RIGHT;
    else if (in_net)   colour = COL_NET;
    else               colour = COL_BLACK;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) {oRed, oGreen, oBlue} <= COL_BLACK;
    else         {oRed, oGreen, oBlue} <= iRequest ? colour : COL_BLACK;
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: frames are compressed to a short
// H/V=0 pulse so full rallies fit in a few thousand cycles.
module tb_pong_frame_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] h_cont, v_cont;
  logic        request;
  logic [11:0] hand_min, hand_max;
  logic        start;
  logic [7:0]  red, green, blue;
  logic [3:0]  score_l, score_r;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] GREY  = 24'h808080;
  localparam logic [23:0] BLACK = 24'h000000;

  pong_frame_renderer dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iH_Cont    (h_cont),
    .iV_Cont    (v_cont),
    .iRequest   (request),
    .iHand_y_min(hand_min),
    .iHand_y_max(hand_max),
    .iStart     (start),
    .oRed       (red),
    .oGreen     (green),
    .oBlue      (blue),
    .oScore_L   (score_l),
    .oScore_R   (score_r),
    .oState     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One compressed frame: counters at 0,0 for a cycle, then the update cycle.
  task automatic do_tick();
    @(negedge clk);
    h_cont = 13'd0;
    v_cont = 13'd0;
    @(negedge clk);
    h_cont = 13'd1;
    v_cont = 13'd1;
    @(negedge clk);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    @(negedge clk);
    h_cont = 13'(144 + x);
    v_cont = 13'(34 + y);
    @(negedge clk);
    check(tag, {8'h00, red, green, blue}, {8'h00, exp});
  endtask

  task automatic check_game(input string tag, input logic [1:0] st,
                            input logic [3:0] sl, input logic [3:0] sr);
    check({tag, "_state"}, {30'd0, state}, {30'd0, st});
    check({tag, "_score_l"}, {28'd0, score_l}, {28'd0, sl});
    check({tag, "_score_r"}, {28'd0, score_r}, {28'd0, sr});
  endtask

  initial begin
    rst_n    = 1'b0;
    h_cont   = 13'd1;
    v_cont   = 13'd1;
    request  = 1'b1;
    hand_min = 12'd300;
    hand_max = 12'd100;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rgb", {8'h00, red, green, blue}, 32'h0);
    check_game("reset", 2'd0, 4'd0, 4'd0);
    rst_n = 1'b1;

    // Frame 1: serve layout
    do_tick();
    check_game("frame1", 2'd0, 4'd0, 4'd0);
    pix("ball_centre", 320, 240, WHITE);
    pix("origin_black", 0, 0, BLACK);
    pix("net_top", 318, 0, GREY);
    pix("net_gap", 318, 16, BLACK);
    pix("left_pad_reset", 16, 208, GREEN);
    pix("right_pad_top", 614, 208, BLUE);
    pix("right_pad_corner", 623, 271, BLUE);
    pix("right_pad_edge", 624, 271, BLACK);

    // Hand box 100..200 -> top 150-32 = 118
    hand_min = 12'd100;
    hand_max = 12'd200;
    do_tick();
    pix("left_top", 20, 118, GREEN);
    pix("left_bottom", 20, 181, GREEN);
    pix("left_above", 20, 117, BLACK);
    pix("left_below", 20, 182, BLACK);

    // Inverted box means no hand: paddle holds
    hand_min = 12'd200;
    hand_max = 12'd100;
    do_tick();
    pix("left_hold", 20, 118, GREEN);
    request = 1'b0;
    pix("blank_no_request", 320, 240, BLACK);
    request = 1'b1;

    // Serve lasts 60 ticks from reset (3 used so far)
    do_ticks(56);
    check("serve_59", {30'd0, state}, 32'd0);
    pix("serve_ball_held", 320, 240, WHITE);
    do_tick();
    check("serve_60_play", {30'd0, state}, 32'd1);

    // Ball (316,236) +4/+4; bottom bounce at play tick 59 (y=472); right paddle hit at 73
    do_ticks(72);
    pix("ball_t72", 604, 420, WHITE);
    do_tick();
    pix("hit_flush", 606, 416, WHITE);
    pix("hit_corner", 613, 423, WHITE);
    pix("hit_left_of_ball", 605, 416, BLACK);
    check_game("after_hit", 2'd1, 4'd0, 4'd0);
    do_tick();
    pix("ball_moving_left", 602, 412, WHITE);
    pix("ball_old_spot", 610, 412, BLACK);

    // Hand 0..10 -> top 5-32 clamps to 0, out of the ball's path
    hand_min = 12'd0;
    hand_max = 12'd10;
    do_tick();
    pix("left_clamp_top", 20, 0, GREEN);
    pix("left_clamp_bottom", 20, 63, GREEN);
    pix("left_clamp_below", 20, 64, BLACK);

    // Leftward: x=606-4m, top bounce at m=104, miss at m=152 (x=-2)
    do_ticks(149);
    check_game("before_miss", 2'd1, 4'd0, 4'd0);
    do_tick();
    check_game("after_miss", 2'd0, 4'd0, 4'd1);
    pix("recentred", 320, 240, WHITE);

    // Every later round replays the same 285-tick rally
    for (int r = 2; r <= 9; r++) begin
      do_ticks(285);
      check("round_score_r", {28'd0, score_r}, 32'(r));
    end
    check_game("game_over", 2'd2, 4'd0, 4'd9);
    pix("ball_hidden", 320, 240, BLACK);

    // In OVER the left paddle ignores the hand
    hand_min = 12'd100;
    hand_max = 12'd200;
    do_tick();
    check("over_stays", {30'd0, state}, 32'd2);
    pix("over_left_hold", 20, 0, GREEN);
    pix("over_left_not_moved", 20, 118, BLACK);

    start = 1'b1;
    do_tick();
    start = 1'b0;
    check_game("restart", 2'd0, 4'd0, 4'd0);
    pix("restart_ball", 320, 240, WHITE);

    do_ticks(60);
    check("restart_play", {30'd0, state}, 32'd1);

    // Asynchronous reset between clock edges while a ball pixel is showing
    pix("pre_reset_ball", 320, 240, WHITE);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", {8'h00, red, green, blue}, 32'h0);
    check("async_rst_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pix("after_reset_ball", 320, 240, WHITE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
